wave_controller: RTL

Sequencing controller for the waveshaper datapath. Owns the mode FSM (off/square/saw/triangle) and the oscillator phase counter, and schedules the sequential divider once per sample period. Presents a coherent `{mode, count}` snapshot to the divider and waveshaper, and pulses `sample_load` when the shaped sample is valid for the PWM stage.

---
 rtl/wave_controller.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/wave_controller.sv
// wave_controller: mode FSM, oscillator phase counter and once-per-sample divider scheduler.
// Define WAVE_CTRL_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module wave_controller #(
    parameter int SAMPLE_PERIOD = 256,
    parameter int COUNT_W       = 19
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               mode_btn,
    input  logic [COUNT_W-1:0] divisor,
    input  logic               div_done,
    output logic [2:0]         mode,
    output logic [COUNT_W-1:0] count,
    output logic               div_start,
    output logic               sample_load,
    output logic               overrun
`ifdef WAVE_CTRL_OVERRUN_CNT_EN
    ,
    output logic [7:0]         overrun_cnt
`endif
);

    localparam int              PS_W    = $clog2(SAMPLE_PERIOD);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {M_OFF, M_SQUARE, M_SAW, M_TRI} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_LOAD} sched_t;

    mode_t              r_live_mode, w_mode_nxt;
    sched_t             r_state, w_state_nxt;
    logic               r_btn_q;
    logic [COUNT_W-1:0] r_div_q;
    logic [COUNT_W-1:0] r_osc, w_osc_nxt;
    logic [PS_W-1:0]    r_presc;
    logic [2:0]         r_mode, w_snap_mode;
    logic [COUNT_W-1:0] r_count, w_snap_count;
    logic               w_snap_en;
    logic               w_tick;
    logic               w_drop;
    logic               r_overrun;

    assign w_tick  = (r_presc == PS_LAST);
    assign w_drop  = w_tick && (r_state != S_IDLE);
    assign mode    = r_mode;
    assign count   = r_count;
    assign overrun = r_overrun;

    // Only a rising edge advances, so holding the button counts once.
    always_comb begin
        w_mode_nxt = r_live_mode;
        if (mode_btn && !r_btn_q) begin
            case (r_live_mode)
                M_OFF:    w_mode_nxt = M_SQUARE;
                M_SQUARE: w_mode_nxt = M_SAW;
                M_SAW:    w_mode_nxt = M_TRI;
                default:  w_mode_nxt = M_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_live_mode <= M_OFF;
            r_btn_q     <= 1'b0;
        end else begin
            r_live_mode <= w_mode_nxt;
            r_btn_q     <= mode_btn;
        end
    end

    // A note change restarts the phase at 0 rather than carrying an out-of-range count.
    always_comb begin
        w_osc_nxt = r_osc + COUNT_W'(1);
        if ((r_live_mode == M_OFF) || (divisor == '0) || (divisor != r_div_q) ||
            (r_osc >= divisor - COUNT_W'(1)))
            w_osc_nxt = '0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_div_q <= '0;
            r_osc   <= '0;
            r_presc <= '0;
        end else begin
            r_div_q <= divisor;
            r_osc   <= w_osc_nxt;
            r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_snap_en    = 1'b0;
        w_snap_mode  = 3'd0;
        w_snap_count = '0;
        div_start    = 1'b0;
        sample_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_snap_en = 1'b1;
                    if (r_live_mode == M_OFF) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_snap_mode  = {1'b0, r_live_mode};
                        w_snap_count = r_osc;
                        w_state_nxt  = S_START;
                    end
                end
            end
            S_START: begin
                div_start   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (div_done)
                    w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                sample_load = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Snapshot only moves in IDLE, so an in-flight divide always sees a stable {mode, count}.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 3'd0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_snap_en) begin
                r_mode  <= w_snap_mode;
                r_count <= w_snap_count;
            end
            if (w_drop)
                r_overrun <= 1'b1;
        end
    end

`ifdef WAVE_CTRL_OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_ovr_cnt <= 8'd0;
        else if (w_drop && (r_ovr_cnt != 8'hFF))
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end

    assign overrun_cnt = r_ovr_cnt;
`endif

endmodule
